// File: rtl/mul_recon.sv
// Sequential shift-add multiply-accumulate: dividend = quotient*divisor + remainder.
// Optional MUL_RECON_OVF_EN adds an ovf output flagging results wider than WIDTH bits.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | one shift-add step per cycle, WIDTH steps total
// DONE  | result loaded, done high for this one cycle; start here begins the next op
module mul_recon #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     remainder,
    output logic [2*WIDTH-1:0]   dividend,
    output logic                 busy,
`ifdef MUL_RECON_OVF_EN
    output logic                 ovf,
`endif
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc_next;
    logic               last;

    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            dividend <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef MUL_RECON_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc    <= {{WIDTH{1'b0}}, remainder};
                        mcand  <= {{WIDTH{1'b0}}, divisor};
                        mplier <= quotient;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end else begin
                        state  <= IDLE;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // final step: capture the accumulated sum directly into the output
                    if (last) begin
                        dividend <= acc_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
`ifdef MUL_RECON_OVF_EN
                        ovf      <= |acc_next[2*WIDTH-1:WIDTH];
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_recon.sv
// Self-checking bench for mul_recon (WIDTH=4): vector table plus multi-cycle corner sequences.
// Define MUL_RECON_OVF_EN for both bench and design to exercise the ovf output.
module tb_mul_recon;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   quotient, divisor, remainder;
    logic [2*W-1:0] dividend;
    logic           busy, done, ovf;

    int tests = 0;
    int fails = 0;
    logic [2*W-1:0] exp_q [$];
    logic           ovf_q [$];

    typedef struct {
        logic [W-1:0]   q, d, r;
        logic [2*W-1:0] res;
        logic           ov;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

`ifndef MUL_RECON_OVF_EN
    assign ovf = 1'b0;
`endif

    mul_recon #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .dividend  (dividend),
        .busy      (busy),
`ifdef MUL_RECON_OVF_EN
        .ovf       (ovf),
`endif
        .done      (done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic pop_check(input string nm);
        logic [2*W-1:0] e;
        logic           eo;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: unexpected done, got dividend %0d, expected no result", nm, dividend);
        end else begin
            e  = exp_q.pop_front();
            eo = ovf_q.pop_front();
            chk({nm, "_dividend"}, int'(dividend), int'(e));
`ifdef MUL_RECON_OVF_EN
            chk({nm, "_ovf"}, int'(ovf), int'(eo));
`endif
        end
    endtask

    task automatic drive(input logic s, input logic [W-1:0] q, d, r);
        start = s; quotient = q; divisor = d; remainder = r;
    endtask

    // Called on the negedge after the accepting edge; returns cycles until done and busy count.
    task automatic wait_done(output int cyc, output int bc);
        cyc = 1;
        bc  = 0;
        while (!done && cyc < 20) begin
            if (busy) bc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic idle_check(input string nm, input int n);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk({nm, "_no_done"}, cnt, 0);
    endtask

    task automatic run_op(input string nm, input vec_t v);
        int cyc, bc;
        @(negedge clk);
        drive(1'b1, v.q, v.d, v.r);
        exp_q.push_back(v.res);
        ovf_q.push_back(v.ov);
        @(negedge clk);
        drive(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
        wait_done(cyc, bc);
        chk({nm, "_latency"}, cyc, 5);
        chk({nm, "_busy_cycles"}, bc, 4);
        chk({nm, "_busy_at_done"}, int'(busy), 0);
        if (done) pop_check(nm);
        @(negedge clk);
        chk({nm, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int cyc, bc;

        vecs[0] = '{q: 4'd3,  d: 4'd4,  r: 4'd1,  res: 8'd13,  ov: 1'b0};
        vecs[1] = '{q: 4'd15, d: 4'd15, r: 4'd15, res: 8'd240, ov: 1'b1};
        vecs[2] = '{q: 4'd0,  d: 4'd9,  r: 4'd7,  res: 8'd7,   ov: 1'b0};
        vecs[3] = '{q: 4'd5,  d: 4'd0,  r: 4'd3,  res: 8'd3,   ov: 1'b0};
        vecs[4] = '{q: 4'd1,  d: 4'd1,  r: 4'd0,  res: 8'd1,   ov: 1'b0};
        vecs[5] = '{q: 4'd7,  d: 4'd9,  r: 4'd2,  res: 8'd65,  ov: 1'b1};
        vecs[6] = '{q: 4'd15, d: 4'd1,  r: 4'd0,  res: 8'd15,  ov: 1'b0};
        vecs[7] = '{q: 4'd15, d: 4'd1,  r: 4'd1,  res: 8'd16,  ov: 1'b1};

        rst = 1'b1;
        drive(1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        chk("reset_dividend", int'(dividend), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ovf", int'(ovf), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // start during BUSY is ignored
        @(negedge clk);
        drive(1'b1, 4'd2, 4'd5, 4'd0);
        exp_q.push_back(8'd10);
        ovf_q.push_back(1'b0);
        @(negedge clk);
        drive(1'b0, 4'd2, 4'd5, 4'd0);
        @(negedge clk);
        drive(1'b1, 4'd7, 4'd7, 4'd7);
        @(negedge clk);
        drive(1'b0, 4'd7, 4'd7, 4'd7);
        wait_done(cyc, bc);
        chk("ignore_latency", cyc + 2, 5);
        if (done) pop_check("ignore");
        idle_check("ignore", 8);
        chk("hold_dividend", int'(dividend), 10);

        // dividend is not cleared by a new start
        @(negedge clk);
        drive(1'b1, 4'd1, 4'd1, 4'd0);
        exp_q.push_back(8'd1);
        ovf_q.push_back(1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        chk("hold_during_busy", int'(dividend), 10);
        wait_done(cyc, bc);
        chk("hold_latency", cyc, 5);
        if (done) pop_check("hold");

        // reset mid-operation aborts with no done
        @(negedge clk);
        drive(1'b1, 4'd3, 4'd3, 4'd0);
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_dividend", int'(dividend), 0);
        idle_check("abort", 8);

        // rst wins over start
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 4'd3, 4'd3, 4'd3);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("rst_priority_busy", int'(busy), 0);
        idle_check("rst_priority", 6);

        // back-to-back: start held through DONE
        @(negedge clk);
        drive(1'b1, 4'd1, 4'd1, 4'd1);
        exp_q.push_back(8'd2);
        ovf_q.push_back(1'b0);
        exp_q.push_back(8'd6);
        ovf_q.push_back(1'b0);
        @(negedge clk);
        drive(1'b1, 4'd2, 4'd3, 4'd0);
        wait_done(cyc, bc);
        chk("b2b_first_latency", cyc, 5);
        chk("b2b_first_busy_cycles", bc, 4);
        chk("b2b_gap_busy_low", int'(busy), 0);
        if (done) pop_check("b2b_first");
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        chk("b2b_restart_busy", int'(busy), 1);
        chk("b2b_restart_done_low", int'(done), 0);
        wait_done(cyc, bc);
        chk("b2b_second_latency", cyc, 5);
        chk("b2b_second_busy_cycles", bc, 4);
        if (done) pop_check("b2b_second");
        @(negedge clk);
        chk("b2b_idle_done_low", int'(done), 0);
        chk("b2b_idle_busy_low", int'(busy), 0);

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
